alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Downstream stage of the ALU core. Captures the 2N-bit ALU result, its 3-bit operation code and the destination register address through a valid/ready handshake.
- Sequences the N-bit register-file writes: one write for most operations, two writes (low half, then high half) for multiply.
- Produces registered status flags for branch/compare logic.
- Sits between the ALU core and the register-file write port.

Parameters:
N, 4, ALU operand width; result width is 2N, register-file data width is N
REG_ADDR_W, 3, register-file address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream result valid
in_ready  output  1  stage can accept a result (high only in IDLE)
alu_result  input  2N  ALU output
operation  input  3  ALU operation code of the result
dest_addr  input  REG_ADDR_W  destination register
rf_ready  input  1  register file accepts the write this cycle
rf_we  output  1  register-file write enable
rf_waddr  output  REG_ADDR_W  write address
rf_wdata  output  N  write data
flag_zero  output  1  captured result is zero
flag_hi  output  1  upper half of captured result is nonzero
done  output  1  one-cycle pulse when the final write of a result is accepted

Behaviour:
- Reset forces state IDLE immediately, regardless of clock. All captured registers, rf_we, rf_waddr, rf_wdata, flags and done become 0. in_ready=1, because the stage is in IDLE.
- FSM states: IDLE, WR_LO, WR_HI.
- IDLE:
  - in_ready=1, rf_we=0.
  - On in_valid&in_ready, capture alu_result, operation and dest_addr, update flags, go to WR_LO.
- WR_LO:
  - rf_we=1, rf_waddr=dest, rf_wdata=result[N-1:0].
  - Hold the state and all outputs stable until rf_ready=1.
  - On acceptance: if op==OP_MUL go to WR_HI; otherwise pulse done and go to IDLE.
- WR_HI:
  - rf_we=1, rf_waddr=(dest+1) mod 2^REG_ADDR_W, so address 7 wraps to 0.
  - rf_wdata=result[2N-1:N].
  - Hold until rf_ready=1; on acceptance pulse done and go to IDLE.
- rf_we, rf_waddr, rf_wdata and done are decoded from the state and the captured registers. They must not depend on in_* inputs.
- Latency and throughput:
  - First write is asserted the cycle after the handshake.
  - Minimum 2 cycles per non-multiply result, 3 cycles per multiply.
  - No bypass: in_ready is low in WR_LO and WR_HI. in_valid in those states is ignored and upstream holds its data.
- Flags, loaded only at capture and held until the next capture:
  - flag_zero = (result[2N-1:0]==0) for OP_MUL; (result[N-1:0]==0) for all other ops.
  - flag_hi = |result[2N-1:N], for all ops.
- rf_ready has no effect outside WR_LO and WR_HI.
- Reset mid-write abandons the in-flight result; there is no partial-write recovery.

Decomposition:
- Shared package alu_pkg holds the 3-bit op encoding:
  - OP_ADD=0, OP_AND=1, OP_SUB=2, OP_OR=3
  - OP_XOR=4, OP_MUL=5, OP_DIV=6, OP_SLT=7
- alu_pkg also holds the wb_state_t enum (IDLE, WR_LO, WR_HI). The ALU core shares this package.
- No sub-module; flag logic is small enough to stay inline.

Test Plan:
- Reset held, then released with no traffic -> rf_we=0, done=0, flags=0, in_ready=1 throughout; reset pulse mid-cycle takes effect without a clock edge.
- ADD: alu_result=8'h03, op=0, dest=2, rf_ready=1 -> next cycle rf_we=1, waddr=2, wdata=3, done=1, flag_zero=0, flag_hi=0; in_ready=1 the following cycle.
- MUL: alu_result=8'h78 (12*10), op=5, dest=6 -> cycle+1 write addr 6 data 4'h8; cycle+2 write addr 7 data 4'h7 with done=1; flag_hi=1.
- MUL wrap: alu_result=8'h24, dest=7 -> writes addr 7 data 4, then addr 0 data 2; SUB with alu_result=0 -> flag_zero=1.
- Stall: rf_ready=0 for 3 cycles in WR_LO while in_valid toggles -> rf_we stays 1 with waddr/wdata unchanged, in_ready=0, no capture; write completes when rf_ready rises.
- Reset asserted during WR_HI of a multiply -> rf_we=0 and done=0 immediately; state IDLE; flags 0; next ADD 8'h05 dest 1 writes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and the writeback sequencer states.
// Imported by both the ALU core and the writeback stage.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_AND = 3'd1,
    OP_SUB = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_DIV = 3'd6,
    OP_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

  // Multiply is the only operation whose result spans both halves.
  function automatic logic is_wide_op(input alu_op_t op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_writeback.sv
// ALU writeback stage: captures a 2N-bit result and sequences one or two
// N-bit register-file writes, with registered zero/high-half status flags.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int N          = 4,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*N-1:0]        alu_result,
  input  logic [2:0]            operation,
  input  logic [REG_ADDR_W-1:0] dest_addr,
  input  logic                  rf_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [N-1:0]          rf_wdata,
  output logic                  flag_zero,
  output logic                  flag_hi,
  output logic                  done
);

  wb_state_t             state_q, state_d;
  logic [2*N-1:0]        result_q, result_d;
  alu_op_t               op_q, op_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic                  flag_zero_q, flag_zero_d;
  logic                  flag_hi_q, flag_hi_d;

  logic                  capture;
  logic [REG_ADDR_W-1:0] dest_inc;

  assign capture  = in_valid && (state_q == IDLE);
  assign dest_inc = dest_q + {{(REG_ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    op_d        = op_q;
    dest_d      = dest_q;
    flag_zero_d = flag_zero_q;
    flag_hi_d   = flag_hi_q;

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          result_d  = alu_result;
          op_d      = alu_op_t'(operation);
          dest_d    = dest_addr;
          flag_hi_d = |alu_result[2*N-1:N];
          // Only a multiply result is meaningful across both halves.
          if (is_wide_op(alu_op_t'(operation))) begin
            flag_zero_d = (alu_result == '0);
          end else begin
            flag_zero_d = (alu_result[N-1:0] == '0);
          end
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        if (rf_ready) begin
          state_d = is_wide_op(op_q) ? WR_HI : IDLE;
        end
      end
      WR_HI: begin
        if (rf_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      WR_LO: begin
        rf_we    = 1'b1;
        rf_waddr = dest_q;
        rf_wdata = result_q[N-1:0];
        done     = rf_ready && !is_wide_op(op_q);
      end
      WR_HI: begin
        rf_we    = 1'b1;
        rf_waddr = dest_inc;
        rf_wdata = result_q[2*N-1:N];
        done     = rf_ready;
      end
      default: ;
    endcase
  end

  assign flag_zero = flag_zero_q;
  assign flag_hi   = flag_hi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      op_q        <= OP_ADD;
      dest_q      <= '0;
      flag_zero_q <= 1'b0;
      flag_hi_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      op_q        <= op_d;
      dest_q      <= dest_d;
      flag_zero_q <= flag_zero_d;
      flag_hi_q   <= flag_hi_d;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed-vector bench for alu_writeback with hand-computed expectations.
module tb_alu_writeback;

  localparam int N  = 4;
  localparam int RA = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2*N-1:0] alu_result;
  logic [2:0]    operation;
  logic [RA-1:0] dest_addr;
  logic          rf_ready;
  logic          rf_we;
  logic [RA-1:0] rf_waddr;
  logic [N-1:0]  rf_wdata;
  logic          flag_zero;
  logic          flag_hi;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_writeback #(.N(N), .REG_ADDR_W(RA)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_result (alu_result),
    .operation  (operation),
    .dest_addr  (dest_addr),
    .rf_ready   (rf_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .flag_zero  (flag_zero),
    .flag_hi    (flag_hi),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic we, input logic [RA-1:0] a,
                           input logic [N-1:0] d, input logic dn);
    #1;
    chk({tag, ".we"},   32'(rf_we),    32'(we));
    chk({tag, ".addr"}, 32'(rf_waddr), 32'(a));
    chk({tag, ".data"}, 32'(rf_wdata), 32'(d));
    chk({tag, ".done"}, 32'(done),     32'(dn));
  endtask

  task automatic expect_flags(input string tag, input logic z, input logic h);
    chk({tag, ".fz"}, 32'(flag_zero), 32'(z));
    chk({tag, ".fh"}, 32'(flag_hi),   32'(h));
  endtask

  task automatic expect_idle(input string tag);
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".we"},       32'(rf_we),    32'd0);
    chk({tag, ".done"},     32'(done),     32'd0);
  endtask

  // Present one result for a single cycle; returns just after the capturing edge.
  task automatic send(input logic [2*N-1:0] res, input logic [2:0] op, input logic [RA-1:0] dst);
    in_valid   = 1'b1;
    alu_result = res;
    operation  = op;
    dest_addr  = dst;
    #1;
    chk("send.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    alu_result = '0;
    operation  = '0;
    dest_addr  = '0;
    rf_ready   = 1'b0;

    repeat (2) tick();
    expect_idle("rst_held");
    expect_flags("rst_held", 1'b0, 1'b0);
    chk("rst_held.addr", 32'(rf_waddr), 32'd0);
    chk("rst_held.data", 32'(rf_wdata), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle("rst_idle");
      expect_flags("rst_idle", 1'b0, 1'b0);
    end

    rf_ready = 1'b1;

    // ADD 0x03 -> single write, done in the same cycle
    send(8'h03, 3'd0, 3'd2);
    expect_wr("add", 1'b1, 3'd2, 4'h3, 1'b1);
    expect_flags("add", 1'b0, 1'b0);
    chk("add.in_ready_busy", 32'(in_ready), 32'd0);
    tick();
    expect_idle("add_after");

    // MUL 12*10 = 0x78 to r6/r7
    send(8'h78, 3'd5, 3'd6);
    expect_wr("mul_lo", 1'b1, 3'd6, 4'h8, 1'b0);
    expect_flags("mul", 1'b0, 1'b1);
    tick();
    expect_wr("mul_hi", 1'b1, 3'd7, 4'h7, 1'b1);
    chk("mul_hi.in_ready", 32'(in_ready), 32'd0);
    tick();
    expect_idle("mul_after");

    // MUL 0x24 to r7 -> high half wraps to r0
    send(8'h24, 3'd5, 3'd7);
    expect_wr("mulw_lo", 1'b1, 3'd7, 4'h4, 1'b0);
    tick();
    expect_wr("mulw_hi", 1'b1, 3'd0, 4'h2, 1'b1);
    expect_flags("mulw", 1'b0, 1'b1);
    tick();
    expect_idle("mulw_after");

    // SUB result 0 -> zero flag
    send(8'h00, 3'd2, 3'd3);
    expect_wr("sub0", 1'b1, 3'd3, 4'h0, 1'b1);
    expect_flags("sub0", 1'b1, 1'b0);
    tick();

    // ADD 0x30: non-multiply zero flag looks only at the low half
    send(8'h30, 3'd0, 3'd5);
    expect_wr("add30", 1'b1, 3'd5, 4'h0, 1'b1);
    expect_flags("add30", 1'b1, 1'b1);
    tick();

    // MUL 0x30: whole product nonzero
    send(8'h30, 3'd5, 3'd1);
    expect_flags("mul30", 1'b0, 1'b1);
    expect_wr("mul30_lo", 1'b1, 3'd1, 4'h0, 1'b0);
    tick();
    expect_wr("mul30_hi", 1'b1, 3'd2, 4'h3, 1'b1);
    tick();

    // Stall in WR_LO while upstream keeps presenting other data
    rf_ready = 1'b0;
    send(8'h5A, 3'd4, 3'd4);
    for (int i = 0; i < 3; i++) begin
      in_valid   = (i != 1);
      alu_result = 8'h00;
      operation  = 3'd0;
      dest_addr  = 3'd6;
      expect_wr("stall", 1'b1, 3'd4, 4'hA, 1'b0);
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    rf_ready = 1'b1;
    expect_wr("stall_rel", 1'b1, 3'd4, 4'hA, 1'b1);
    expect_flags("stall_rel", 1'b0, 1'b1);
    tick();
    expect_idle("stall_after");
    expect_flags("stall_after", 1'b0, 1'b1);

    // Asynchronous reset during WR_HI of a multiply
    send(8'hFF, 3'd5, 3'd1);
    expect_wr("rstmul_lo", 1'b1, 3'd1, 4'hF, 1'b0);
    tick();
    expect_wr("rstmul_hi", 1'b1, 3'd2, 4'hF, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rstmul.we",       32'(rf_we),     32'd0);
    chk("rstmul.done",     32'(done),      32'd0);
    chk("rstmul.in_ready", 32'(in_ready),  32'd1);
    chk("rstmul.addr",     32'(rf_waddr),  32'd0);
    chk("rstmul.data",     32'(rf_wdata),  32'd0);
    expect_flags("rstmul", 1'b0, 1'b0);
    #1 reset = 1'b0;
    tick();
    expect_idle("rstmul_after");

    send(8'h05, 3'd0, 3'd1);
    expect_wr("post_rst_add", 1'b1, 3'd1, 4'h5, 1'b1);
    expect_flags("post_rst_add", 1'b0, 1'b0);
    tick();
    expect_idle("post_rst_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
